ika87ad_bus_responder: RTL
==========================

Name: ika87ad_bus_responder

Overview:
External-bus responder for the IKA87AD core: the target side of the CPU's RD_n/WR_n/A/DI/DO bus. It decodes each CPU strobe into one of three regions:
- a ROM/external window, served by a slow req/ack memory port;
- a 256-byte internal RAM at the top of the address space;
- a fixed ID register.
It holds the CPU's clock enable low until the addressed data is ready, so the core can run from slow backing memory, e.g. SDRAM. It sits between the core and the board memory controller.

Parameters:
EXT_END, 16'h1000, external window is A < EXT_END
RAM_BASE, 16'hFF00, internal RAM window is A >= RAM_BASE (256 bytes, index A[7:0])
ID_ADDR, 16'h1401, address of the read-only ID register
ID_VALUE, 8'hEE, value returned at ID_ADDR
OPEN_BUS, 8'hFF, read data for unmapped reads and for timed-out reads
TIMEOUT, 64, EMUCLK cycles to wait for i_MEM_ACK before aborting

Ports:
i_EMUCLK  in  1  system clock
i_RESET_n  in  1  asynchronous active-low reset
i_PCEN_RAW  in  1  free-running CPU clock-enable from the prescaler
o_MCUCLK_PCEN  out  1  gated clock enable to the CPU
i_A  in  16  CPU address
i_RD_n  in  1  CPU read strobe
i_WR_n  in  1  CPU write strobe
i_DO  in  8  CPU write data
o_DI  out  8  read data to the CPU
o_MEM_REQ  out  1  external memory request (level)
o_MEM_WE  out  1  request is a write
o_MEM_ADDR  out  16  latched address
o_MEM_WDATA  out  8  latched write data
i_MEM_RDATA  in  8  external read data, valid when ack is high
i_MEM_ACK  in  1  external acknowledge
o_BUS_ERR  out  1  one-cycle pulse on timeout or on an illegal strobe

Behaviour:
Reset values:
- All registers cleared; FSM in IDLE.
- o_DI = OPEN_BUS; o_MEM_REQ, o_MEM_WE and o_BUS_ERR = 0.
- o_MEM_ADDR and o_MEM_WDATA = 0.
- o_MCUCLK_PCEN = i_PCEN_RAW.
- Asserting reset mid-transaction drops o_MEM_REQ immediately. No completion is issued; the memory controller must tolerate an abandoned request.

Access start:
- Strobes are sampled each i_EMUCLK. A start is detected in cycle T0: the sampled RD_n or WR_n is low and was high in the previous sample, and the FSM is in IDLE.
- At T0 the responder latches i_A and i_DO and classifies the region, in priority order: external, RAM, ID, unmapped.
- If RD_n and WR_n are both low: no access, pulse o_BUS_ERR, go to DONE.

Clock-enable gating:
- o_MCUCLK_PCEN = i_PCEN_RAW & ~stall.
- stall = start detected this cycle (combinational, so it covers T0) OR state in {EXT_RD, EXT_WR, FAST}.

States:
- IDLE: wait for a start. External read -> EXT_RD; external write -> EXT_WR; every other access -> FAST.
- EXT_RD / EXT_WR:
  - o_MEM_REQ = 1 from T0+1, with o_MEM_WE = 1 for writes and the address/data latched.
  - On the cycle Tk where i_MEM_ACK = 1: capture i_MEM_RDATA into o_DI (reads only), drop REQ at Tk+1, go to DONE. Stall is released from Tk+1.
  - If the wait counter reaches TIMEOUT without ack: drop REQ, o_DI = OPEN_BUS, pulse o_BUS_ERR, go to DONE.
- FAST: fixed 2-cycle stall; o_DI is valid and stall released at T0+2.
  - RAM read: o_DI = ram[A[7:0]] (synchronous read).
  - RAM write: ram[A[7:0]] = latched data at T0+1.
  - ID read: o_DI = ID_VALUE.
  - Writes to the ID register or unmapped space are ignored.
  - Unmapped reads return OPEN_BUS.
- DONE: no stall; o_DI holds its value. Return to IDLE when both strobes are sampled high. A re-assertion of a strobe without an intervening release is not a new start.

Further rules:
- Writes to the external window are forwarded to memory; the block does not treat that window as read-only.
- o_DI is registered and holds its last value between accesses.
- A stray i_MEM_ACK outside EXT states is ignored.

Decomposition:
- Package ika87ad_bus_pkg:
  - state enum {IDLE, EXT_RD, EXT_WR, FAST, DONE};
  - region enum {REG_EXT, REG_RAM, REG_ID, REG_NONE};
  - the default window constants.
- Sub-module ika87ad_bus_ram: 256x8 single-port RAM with synchronous read and synchronous write enable, inferable as block RAM.

Test Plan:
1. Read A=16'h0123, i_MEM_ACK returned 5 cycles after REQ with RDATA=8'h5A -> REQ high from T0+1 for 5 cycles, o_DI=8'h5A at Tk+1, o_MCUCLK_PCEN suppressed from T0 to Tk and passing again from Tk+1.
2. Write 8'hC3 to A=16'hFF10, then read A=16'hFF10 -> read returns o_DI=8'hC3; each access stalls exactly 2 cycles; o_MEM_REQ never asserted.
3. Read A=16'h1401 -> o_DI=8'hEE; read A=16'h2000 -> o_DI=8'hFF; no o_BUS_ERR for either.
4. External read with ack never asserted -> after 64 cycles REQ drops, o_BUS_ERR pulses 1 cycle, o_DI=8'hFF, PCEN resumes.
5. Write 8'h77 to A=16'h0800 -> o_MEM_WE=1, ADDR=16'h0800, WDATA=8'h77 held until ack; the block returns to IDLE only after WR_n rises.
6. Reset asserted mid-EXT_RD, and a separate case with RD_n and WR_n both low -> reset drops REQ asynchronously and returns all outputs to reset values; the dual-strobe case pulses o_BUS_ERR with no memory request.

Source files
------------

// File: rtl/ika87ad_bus_pkg.sv
// ika87ad_bus_pkg: shared types, default address windows and region decode for the IKA87AD bus responder
package ika87ad_bus_pkg;

    typedef enum logic [2:0] {IDLE, EXT_RD, EXT_WR, FAST, DONE} state_t;
    typedef enum logic [1:0] {REG_EXT, REG_RAM, REG_ID, REG_NONE} region_t;

    localparam logic [15:0] DEF_EXT_END  = 16'h1000;
    localparam logic [15:0] DEF_RAM_BASE = 16'hFF00;
    localparam logic [15:0] DEF_ID_ADDR  = 16'h1401;
    localparam logic [7:0]  DEF_ID_VALUE = 8'hEE;
    localparam logic [7:0]  DEF_OPEN_BUS = 8'hFF;
    localparam int          DEF_TIMEOUT  = 64;

    function automatic region_t classify(input logic [15:0] a, input logic [15:0] ext_end,
                                         input logic [15:0] ram_base, input logic [15:0] id_addr);
        return (a < ext_end) ? REG_EXT : (a >= ram_base) ? REG_RAM : (a == id_addr) ? REG_ID : REG_NONE;
    endfunction

endpackage

// File: rtl/ika87ad_bus_ram.sv
// ika87ad_bus_ram: 256x8 single-port RAM, synchronous read and write, block-RAM friendly
module ika87ad_bus_ram (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [256];

    // Read-first single port: registered read data, optional write
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/ika87ad_bus_responder.sv
// ika87ad_bus_responder: decodes CPU bus strobes to external/RAM/ID regions and stalls the CPU until data is ready
module ika87ad_bus_responder
    import ika87ad_bus_pkg::*;
#(
    parameter logic [15:0] EXT_END  = DEF_EXT_END,
    parameter logic [15:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [15:0] ID_ADDR  = DEF_ID_ADDR,
    parameter logic [7:0]  ID_VALUE = DEF_ID_VALUE,
    parameter logic [7:0]  OPEN_BUS = DEF_OPEN_BUS,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        i_EMUCLK,
    input  logic        i_RESET_n,
    input  logic        i_PCEN_RAW,
    output logic        o_MCUCLK_PCEN,
    input  logic [15:0] i_A,
    input  logic        i_RD_n,
    input  logic        i_WR_n,
    input  logic [7:0]  i_DO,
    output logic [7:0]  o_DI,
    output logic        o_MEM_REQ,
    output logic        o_MEM_WE,
    output logic [15:0] o_MEM_ADDR,
    output logic [7:0]  o_MEM_WDATA,
    input  logic [7:0]  i_MEM_RDATA,
    input  logic        i_MEM_ACK,
    output logic        o_BUS_ERR
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        r_state, w_next;
    region_t       r_region, w_region;
    logic          r_rd_q, r_wr_q, r_is_wr, r_err;
    logic [15:0]   r_addr;
    logic [7:0]    r_wdata, r_di;
    logic [CW-1:0] r_wait;
    logic          w_start, w_both, w_ext, w_timeout, w_stall, w_ram_we;
    logic [7:0]    w_ram_addr, w_ram_q;

    assign w_both    = ~i_RD_n & ~i_WR_n;
    assign w_start   = (r_state == IDLE) & ((~i_RD_n & r_rd_q) | (~i_WR_n & r_wr_q));
    assign w_region  = classify(i_A, EXT_END, RAM_BASE, ID_ADDR);
    assign w_ext     = (r_state == EXT_RD) | (r_state == EXT_WR);
    assign w_timeout = w_ext & ~i_MEM_ACK & (r_wait == CW'(TIMEOUT - 1));

    assign o_MCUCLK_PCEN = i_PCEN_RAW & ~w_stall;
    assign o_DI          = r_di;
    assign o_MEM_ADDR    = r_addr;
    assign o_MEM_WDATA   = r_wdata;
    assign o_BUS_ERR     = r_err;

    // Previous strobe samples, so a start needs a high-to-low transition
    always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_rd_q <= 1'b0;
            r_wr_q <= 1'b0;
        end else begin
            r_rd_q <= i_RD_n;
            r_wr_q <= i_WR_n;
        end
    end

    // State register
    always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
        if (!i_RESET_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: DONE is left only once both strobes are released
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:           if (w_start) w_next = w_both ? DONE : (w_region != REG_EXT) ? FAST : i_RD_n ? EXT_WR : EXT_RD;
            EXT_RD, EXT_WR: if (i_MEM_ACK | w_timeout) w_next = DONE;
            FAST:           w_next = DONE;
            DONE:           if (i_RD_n & i_WR_n) w_next = IDLE;
            default:        w_next = IDLE;
        endcase
    end

    // State-decoded outputs; RAM address comes straight from the bus at T0 so read data is ready a cycle later
    always_comb begin
        w_stall    = w_start | w_ext | (r_state == FAST);
        o_MEM_REQ  = w_ext;
        o_MEM_WE   = (r_state == EXT_WR);
        w_ram_we   = (r_state == FAST) & r_is_wr & (r_region == REG_RAM);
        w_ram_addr = (r_state == FAST) ? r_addr[7:0] : i_A[7:0];
    end

    // Access latch, ack wait counter, registered read data and error pulse
    always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_region <= REG_EXT;
            r_is_wr  <= 1'b0;
            r_wait   <= '0;
            r_di     <= OPEN_BUS;
            r_err    <= 1'b0;
        end else begin
            r_err  <= (w_start & w_both) | w_timeout;
            r_wait <= w_ext ? r_wait + 1'b1 : '0;
            if (w_start) begin
                r_addr   <= i_A;
                r_wdata  <= i_DO;
                r_region <= w_region;
                r_is_wr  <= ~i_WR_n;
            end
            if ((r_state == EXT_RD) & i_MEM_ACK) r_di <= i_MEM_RDATA;
            else if (w_timeout) r_di <= OPEN_BUS;
            else if ((r_state == FAST) & ~r_is_wr)
                r_di <= (r_region == REG_RAM) ? w_ram_q : (r_region == REG_ID) ? ID_VALUE : OPEN_BUS;
        end
    end

    ika87ad_bus_ram u_ram (
        .i_clk   (i_EMUCLK),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

endmodule
